// File: rtl/fetch_stage.sv
// fetch_stage: keeps the PC and issues one 32-bit instruction fetch at a time,
// buffering returned words in an IF/ID register (plus a one-entry skid
// register) and applying branch redirects computed from a downstream immediate.
module fetch_stage #(
    parameter int            N        = 64,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [N-1:0]     imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [N/2-1:0]   imem_rdata,
    output logic             if_valid,
    output logic [N/2-1:0]   if_instr,
    output logic [N-1:0]     if_pc,
    input  logic             id_ready,
    input  logic             redirect,
    input  logic [N-1:0]     redirect_pc,
    input  logic [N-1:0]     redirect_imm
);

    localparam int W = N / 2;

    // REQ: request presented; WAIT: one fetch outstanding; HOLD: word parked in skid
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   pc;
    logic           drop;
    logic [W-1:0]   skid;
    logic [N-1:0]   target;
    logic [N-1:0]   pc_next;
    logic           slot_free;

    // Branch target: immediate is in halfword units, result forced word aligned
    always_comb begin
        target      = redirect_pc + (redirect_imm << 1);
        target[1:0] = 2'b00;
    end

    assign pc_next   = pc + N'(4);
    // The IF/ID slot can take a word if empty or being consumed this cycle
    assign slot_free = !if_valid || id_ready;
    assign imem_req  = (state == S_REQ) && !rst;
    assign imem_addr = pc;

    // Fetch FSM together with PC, drop flag, IF/ID register and skid register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            skid     <= '0;
        end else if (redirect) begin
            pc       <= target;
            if_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    drop  <= !imem_rvalid;
                    state <= imem_rvalid ? S_REQ : S_WAIT;
                end
                default: begin
                    state <= S_REQ;
                    drop  <= 1'b0;
                end
            endcase
        end else begin
            if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else if (slot_free) begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            pc       <= pc_next;
                            state    <= S_REQ;
                        end else begin
                            skid  <= imem_rdata;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        if_valid <= 1'b1;
                        if_instr <= skid;
                        if_pc    <= pc;
                        pc       <= pc_next;
                        state    <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: exercises fetch_stage with a small instruction-memory model
// and a stream-level reference of which (pc, instruction) pairs decode sees.
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] redirect_imm;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory model settings and state
    int          gnt_prob = 100;
    int          lat_min  = 0;
    int          lat_max  = 0;
    bit          mem_busy = 0;
    logic [63:0] mem_addr = '0;
    int          mem_cnt  = 0;

    // Stream reference: next PC decode should receive
    logic [63:0] exp_pc = RST_PC;
    logic [63:0] obs_pc_q[$];
    logic [31:0] obs_instr_q[$];
    logic [63:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];

    bit          prev_hold  = 0;
    bit          prev_flush = 0;
    logic [63:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;
    int          stab_viol  = 0;
    int          flush_viol = 0;
    int          req_viol   = 0;

    fetch_stage #(.N(64), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .redirect_imm (redirect_imm)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] branch_target(input logic [63:0] bpc, input logic [63:0] imm);
        logic [63:0] t;
        t = bpc + imm * 64'd2;
        return t & ~64'h3;
    endfunction

    // One clock cycle: memory responds, reference stream advances. Called at negedge.
    task automatic tick();
        logic        v;
        logic        rq;
        logic [63:0] p;
        logic [63:0] ad;
        logic [31:0] ins;
        #1;
        v = if_valid; rq = imem_req; p = if_pc; ad = imem_addr; ins = if_instr;
        if (prev_hold && (v !== 1'b1 || p !== prev_pc || ins !== prev_instr)) stab_viol++;
        if (prev_flush && v !== 1'b0) flush_viol++;
        if (rq === 1'b1 && mem_busy) req_viol++;
        imem_rvalid = mem_busy && (mem_cnt == 0) && !rst;
        imem_rdata  = imem_rvalid ? word_of(mem_addr) : $urandom;
        imem_gnt    = (rq === 1'b1) && ($urandom_range(99) < gnt_prob);
        if (rst) begin
            exp_pc = RST_PC;
        end else begin
            if (v === 1'b1 && id_ready) begin
                obs_pc_q.push_back(p);
                obs_instr_q.push_back(ins);
                exp_pc_q.push_back(exp_pc);
                exp_instr_q.push_back(word_of(exp_pc));
                exp_pc = exp_pc + 64'd4;
            end
            if (redirect) exp_pc = branch_target(redirect_pc, redirect_imm);
        end
        prev_hold  = (v === 1'b1) && !id_ready && !redirect && !rst;
        prev_flush = redirect && !rst;
        prev_pc    = p;
        prev_instr = ins;
        @(posedge clk);
        if (rst) begin
            mem_busy = 0;
        end else begin
            if (imem_rvalid) mem_busy = 0;
            else if (mem_busy && mem_cnt > 0) mem_cnt--;
            if (imem_gnt) begin
                mem_busy = 1;
                mem_addr = ad;
                mem_cnt  = $urandom_range(lat_max, lat_min);
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_log();
        obs_pc_q.delete(); obs_instr_q.delete(); exp_pc_q.delete(); exp_instr_q.delete();
    endtask

    task automatic do_reset();
        rst = 1; redirect = 0; id_ready = 0;
        tick(); tick();
        rst = 0;
        clear_log();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        gnt_prob = 100; lat_min = 0; lat_max = 0;
        rst = 1; redirect = 0; id_ready = 0;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %0b expected 0", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", if_valid); end
        n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 0", if_instr); end
        n_cmp++; if (if_pc !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_ifpc: got %h expected 0", if_pc); end
        n_cmp++; if (imem_addr !== RST_PC) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
        rst = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_req: got %0b expected 1", imem_req); end
        clear_log();
    endtask

    task automatic test_sequential();
        $display("[TB] test_sequential");
        do_reset();
        gnt_prob = 100; lat_min = 0; lat_max = 0; id_ready = 1;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin n_fail++; $display("[TB] FAIL seq_first: got valid=%0b pc=%h expected 1/%h", if_valid, if_pc, RST_PC); end
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (obs_pc_q.size() != 3) begin n_fail++; $display("[TB] FAIL seq_count: got %0d expected 3", obs_pc_q.size()); end
        for (int i = 0; i < 3 && i < obs_pc_q.size(); i++) begin
            n_cmp++; if (obs_pc_q[i] !== RST_PC + 64'(4 * i)) begin n_fail++; $display("[TB] FAIL seq_pc[%0d]: got %h expected %h", i, obs_pc_q[i], RST_PC + 64'(4 * i)); end
            n_cmp++; if (obs_instr_q[i] !== word_of(RST_PC + 64'(4 * i))) begin n_fail++; $display("[TB] FAIL seq_instr[%0d]: got %h expected %h", i, obs_instr_q[i], word_of(RST_PC + 64'(4 * i))); end
        end
    endtask

    task automatic test_stall();
        $display("[TB] test_stall");
        do_reset();
        gnt_prob = 100; lat_min = 0; lat_max = 0; id_ready = 0;
        tick(); tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin n_fail++; $display("[TB] FAIL stall_load: got valid=%0b pc=%h expected 1/%h", if_valid, if_pc, RST_PC); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== word_of(RST_PC)) begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got valid=%0b pc=%h instr=%h expected 1/%h/%h", k, if_valid, if_pc, if_instr, RST_PC, word_of(RST_PC)); end
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_noreq[%0d]: got %0b expected 0", k, imem_req); end
        end
        id_ready = 1;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== RST_PC + 64'd4 || if_instr !== word_of(RST_PC + 64'd4)) begin n_fail++; $display("[TB] FAIL stall_skid: got valid=%0b pc=%h instr=%h expected 1/%h/%h", if_valid, if_pc, if_instr, RST_PC + 64'd4, word_of(RST_PC + 64'd4)); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 64'd8) begin n_fail++; $display("[TB] FAIL stall_next_req: got req=%0b addr=%h expected 1/%h", imem_req, imem_addr, RST_PC + 64'd8); end
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain: got %0b expected 0", if_valid); end
        n_cmp++; if (obs_pc_q.size() != 2) begin n_fail++; $display("[TB] FAIL stall_count: got %0d expected 2", obs_pc_q.size()); end
        for (int i = 0; i < 2 && i < obs_pc_q.size(); i++) begin
            n_cmp++; if (obs_pc_q[i] !== RST_PC + 64'(4 * i) || obs_instr_q[i] !== word_of(RST_PC + 64'(4 * i))) begin n_fail++; $display("[TB] FAIL stall_order[%0d]: got %h/%h expected %h/%h", i, obs_pc_q[i], obs_instr_q[i], RST_PC + 64'(4 * i), word_of(RST_PC + 64'(4 * i))); end
        end
    endtask

    task automatic test_redirect_wait();
        $display("[TB] test_redirect_wait");
        do_reset();
        gnt_prob = 100; lat_min = 2; lat_max = 2; id_ready = 1;
        tick();
        redirect = 1; redirect_pc = 64'h2000; redirect_imm = 64'h10;
        tick();
        redirect = 0;
        n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_wait: got req=%0b valid=%0b expected 0/0", imem_req, if_valid); end
        n_cmp++; if (imem_addr !== 64'h2020) begin n_fail++; $display("[TB] FAIL rw_addr: got %h expected 2020", imem_addr); end
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h2020 || if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_drop: got req=%0b addr=%h valid=%0b expected 1/2020/0", imem_req, imem_addr, if_valid); end
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'h2020 || if_instr !== word_of(64'h2020)) begin n_fail++; $display("[TB] FAIL rw_new: got valid=%0b pc=%h instr=%h expected 1/2020/%h", if_valid, if_pc, if_instr, word_of(64'h2020)); end
    endtask

    task automatic test_redirect_req();
        $display("[TB] test_redirect_req");
        do_reset();
        gnt_prob = 100; lat_min = 0; lat_max = 0; id_ready = 1;
        tick();
        redirect = 1; redirect_pc = 64'h2000; redirect_imm = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redirect = 0;
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h1FF0) begin n_fail++; $display("[TB] FAIL rn_same: got valid=%0b req=%0b addr=%h expected 0/1/1ff0", if_valid, imem_req, imem_addr); end
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'h1FF0 || if_instr !== word_of(64'h1FF0)) begin n_fail++; $display("[TB] FAIL rn_word: got valid=%0b pc=%h instr=%h expected 1/1ff0/%h", if_valid, if_pc, if_instr, word_of(64'h1FF0)); end
        redirect = 1; redirect_pc = 64'h3000; redirect_imm = 64'h4;
        tick();
        redirect = 0;
        n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 64'h3008) begin n_fail++; $display("[TB] FAIL rg_wait: got req=%0b valid=%0b addr=%h expected 0/0/3008", imem_req, if_valid, imem_addr); end
        tick();
        n_cmp++; if (imem_req !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rg_drop: got req=%0b valid=%0b expected 1/0", imem_req, if_valid); end
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'h3008 || if_instr !== word_of(64'h3008)) begin n_fail++; $display("[TB] FAIL rg_word: got valid=%0b pc=%h instr=%h expected 1/3008/%h", if_valid, if_pc, if_instr, word_of(64'h3008)); end
        gnt_prob = 0;
        redirect = 1; redirect_pc = 64'h4000; redirect_imm = 64'h0;
        tick();
        redirect = 0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 64'h4000) begin n_fail++; $display("[TB] FAIL rq_nogrant: got req=%0b addr=%h expected 1/4000", imem_req, imem_addr); end
    endtask

    task automatic test_wrap_and_reset();
        $display("[TB] test_wrap_and_reset");
        do_reset();
        gnt_prob = 0; lat_min = 0; lat_max = 0; id_ready = 0;
        redirect = 1; redirect_pc = 64'h0; redirect_imm = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect = 0;
        n_cmp++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_target: got %h expected fffffffffffffffc", imem_addr); end
        gnt_prob = 100;
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_word: got valid=%0b pc=%h expected 1/fffffffffffffffc", if_valid, if_pc); end
        n_cmp++; if (imem_addr !== 64'h0) begin n_fail++; $display("[TB] FAIL wrap_next: got %h expected 0", imem_addr); end
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_reach: got req=%0b valid=%0b expected 0/1", imem_req, if_valid); end
        rst = 1;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_rst: got valid=%0b req=%0b expected 0/0", if_valid, imem_req); end
        rst = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("[TB] FAIL hold_rst_req: got req=%0b addr=%h expected 1/%h", imem_req, imem_addr, RST_PC); end
        id_ready = 1;
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== word_of(RST_PC)) begin n_fail++; $display("[TB] FAIL hold_rst_word: got valid=%0b pc=%h instr=%h expected 1/%h/%h", if_valid, if_pc, if_instr, RST_PC, word_of(RST_PC)); end
    endtask

    task automatic test_random();
        int s;
        $display("[TB] test_random");
        do_reset();
        gnt_prob = 60; lat_min = 0; lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(999) < 3);
            id_ready = ($urandom_range(99) < 70);
            redirect = !rst && ($urandom_range(99) < 5);
            s = int'($urandom_range(4095)) - 2048;
            redirect_imm = 64'(s);
            if ($urandom_range(9) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
            else redirect_pc = {$urandom, $urandom} & ~64'h3;
            tick();
        end
        rst = 0; redirect = 0; id_ready = 1;
        for (int k = 0; k < 10; k++) tick();
        n_cmp++; if (obs_pc_q.size() < 100) begin n_fail++; $display("[TB] FAIL rand_progress: got %0d deliveries expected at least 100", obs_pc_q.size()); end
        for (int i = 0; i < obs_pc_q.size(); i++) begin
            n_cmp++; if (obs_pc_q[i] !== exp_pc_q[i]) begin n_fail++; $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", i, obs_pc_q[i], exp_pc_q[i]); end
            n_cmp++; if (obs_instr_q[i] !== exp_instr_q[i]) begin n_fail++; $display("[TB] FAIL rand_instr[%0d]: got %h expected %h", i, obs_instr_q[i], exp_instr_q[i]); end
        end
    endtask

    task automatic test_protocol();
        $display("[TB] test_protocol");
        n_cmp++; if (stab_viol != 0) begin n_fail++; $display("[TB] FAIL hold_stability: got %0d violations expected 0", stab_viol); end
        n_cmp++; if (flush_viol != 0) begin n_fail++; $display("[TB] FAIL redirect_flush: got %0d violations expected 0", flush_viol); end
        n_cmp++; if (req_viol != 0) begin n_fail++; $display("[TB] FAIL single_outstanding: got %0d violations expected 0", req_viol); end
    endtask

    // Test sequence
    initial begin
        clk = 0; rst = 1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        id_ready = 0; redirect = 0; redirect_pc = '0; redirect_imm = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_wrap_and_reset();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
